// File: rtl/riscv_pkg.sv
// Shared RV32I encodings and pipeline-register types for the memory stage.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef enum logic {IDLE, BUSY} mem_state_e;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic        reg_write;
      logic [1:0]  result_src;
      logic [31:0] alu_result;
      logic [31:0] mem_data;
      logic [31:0] pc_plus4;
   } mem_wb_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane select plus extension for loads.
module lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rs2,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic        misaligned
);

   logic [7:0]  byte_l;
   logic [15:0] half_l;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_l = rdata[7:0];
         2'd1:    byte_l = rdata[15:8];
         2'd2:    byte_l = rdata[23:16];
         default: byte_l = rdata[31:24];
      endcase
      half_l = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // funct3[2] marks the unsigned load variants
   always_comb begin
      be         = '0;
      wdata      = '0;
      ldata      = '0;
      misaligned = 1'b0;
      case (funct3)
         F3_B, F3_BU: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{rs2[7:0]}};
            ldata = funct3[2] ? {24'b0, byte_l} : {{24{byte_l[7]}}, byte_l};
         end
         F3_H, F3_HU: begin
            be         = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{rs2[15:0]}};
            ldata      = funct3[2] ? {16'b0, half_l} : {{16{half_l[15]}}, half_l};
            misaligned = addr_lo[0];
         end
         F3_W: begin
            be         = 4'b1111;
            wdata      = rs2;
            ldata      = rdata;
            misaligned = |addr_lo;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: single-outstanding load/store over a req/ack bus with
// ack timeout, registered MEM/WB bundle, and upstream stall.
module mem_stage
   import riscv_pkg::*;
#(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_rs2_data,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   input  logic [1:0]  ex_result_src,
   input  logic [31:0] ex_pc_plus4,
   output logic        stall_o,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic [1:0]  wb_result_src,
   output logic [31:0] wb_alu_result,
   output logic [31:0] wb_mem_data,
   output logic [31:0] wb_pc_plus4,
   output logic        misalign_o,
   output logic        bus_err_o
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   mem_state_e     state;
   logic [CW-1:0]  tmo_cnt;
   mem_wb_t        q_inst, wb_d, wb_q;
   logic [2:0]     q_funct3;
   logic           q_we;
   logic [31:0]    q_wdata;
   logic [3:0]     q_be;

   logic           busy, is_mem, start, mis, expire, done;
   logic [2:0]     al_f3;
   logic [1:0]     al_lo;
   logic [3:0]     al_be;
   logic [31:0]    al_wdata, al_ldata;
   logic           al_mis;

   assign busy   = (state == BUSY);
   assign is_mem = ex_valid & (ex_mem_read | ex_mem_write);

   // IDLE steers the incoming op for lane setup; BUSY reuses the aligner for load data
   assign al_f3 = busy ? q_funct3 : ex_funct3;
   assign al_lo = busy ? q_inst.alu_result[1:0] : ex_alu_result[1:0];

   lsu_align u_align (
      .funct3     (al_f3),
      .addr_lo    (al_lo),
      .rs2        (ex_rs2_data),
      .rdata      (dmem_rdata),
      .be         (al_be),
      .wdata      (al_wdata),
      .ldata      (al_ldata),
      .misaligned (al_mis)
   );

   assign start  = ~busy & is_mem & ~al_mis;
   assign mis    = ~busy & is_mem & al_mis;
   assign expire = busy & ~dmem_ack & (tmo_cnt == CW'(ACK_TIMEOUT - 1));
   assign done   = busy & (dmem_ack | expire);

   assign stall_o    = rst_n & (start | (busy & ~done));
   assign dmem_req   = busy;
   assign dmem_we    = busy & q_we;
   assign dmem_addr  = busy ? {q_inst.alu_result[31:2], 2'b00} : '0;
   assign dmem_wdata = busy ? q_wdata : '0;
   assign dmem_be    = busy ? q_be : '0;

   always_comb begin
      wb_d = '0;
      if (busy) begin
         if (done) begin
            wb_d = q_inst;
            wb_d.reg_write = q_inst.reg_write & dmem_ack & ~q_we;
            wb_d.mem_data  = (dmem_ack & ~q_we) ? al_ldata : '0;
         end
      end else if (!start) begin
         wb_d.valid      = ex_valid;
         wb_d.rd         = ex_rd;
         wb_d.reg_write  = ex_valid & ex_reg_write & ~mis;
         wb_d.result_src = ex_result_src;
         wb_d.alu_result = ex_alu_result;
         wb_d.pc_plus4   = ex_pc_plus4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tmo_cnt    <= '0;
         q_inst     <= '0;
         q_funct3   <= '0;
         q_we       <= 1'b0;
         q_wdata    <= '0;
         q_be       <= '0;
         wb_q       <= '0;
         misalign_o <= 1'b0;
         bus_err_o  <= 1'b0;
      end else begin
         wb_q       <= wb_d;
         misalign_o <= mis;
         bus_err_o  <= expire;
         if (start) begin
            state    <= BUSY;
            tmo_cnt  <= '0;
            q_inst   <= '{valid: 1'b1, rd: ex_rd, reg_write: ex_reg_write,
                          result_src: ex_result_src, alu_result: ex_alu_result,
                          mem_data: 32'h0, pc_plus4: ex_pc_plus4};
            q_funct3 <= ex_funct3;
            q_we     <= ex_mem_write;
            q_wdata  <= ex_mem_write ? al_wdata : '0;
            q_be     <= al_be;
         end else if (done) begin
            state <= IDLE;
         end else if (busy) begin
            tmo_cnt <= tmo_cnt + CW'(1);
         end
      end
   end

   assign wb_valid      = wb_q.valid;
   assign wb_rd         = wb_q.rd;
   assign wb_reg_write  = wb_q.reg_write;
   assign wb_result_src = wb_q.result_src;
   assign wb_alu_result = wb_q.alu_result;
   assign wb_mem_data   = wb_q.mem_data;
   assign wb_pc_plus4   = wb_q.pc_plus4;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, loads, misalignment, ack timeout, async reset.
module tb_mem_stage;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_alu_result, ex_rs2_data, ex_pc_plus4;
   logic [4:0]  ex_rd;
   logic [1:0]  ex_result_src;
   logic        stall_o, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        wb_valid, wb_reg_write, misalign_o, bus_err_o;
   logic [4:0]  wb_rd;
   logic [1:0]  wb_result_src;
   logic [31:0] wb_alu_result, wb_mem_data, wb_pc_plus4;

   int checks = 0;
   int failures = 0;

   logic [3:0]  be_seen;
   logic [31:0] wdata_seen, addr_seen;
   logic        we_seen, stall_ack_seen;

   always #5 clk = ~clk;

   mem_stage #(.ACK_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_result_src(ex_result_src),
      .ex_pc_plus4(ex_pc_plus4), .stall_o(stall_o),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .wb_result_src(wb_result_src), .wb_alu_result(wb_alu_result),
      .wb_mem_data(wb_mem_data), .wb_pc_plus4(wb_pc_plus4),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic v, input logic rd_en, input logic wr_en,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd, input logic rw, input logic [1:0] rs);
      ex_valid      = v;
      ex_mem_read   = rd_en;
      ex_mem_write  = wr_en;
      ex_funct3     = f3;
      ex_alu_result = a;
      ex_rs2_data   = d;
      ex_rd         = rd;
      ex_reg_write  = rw;
      ex_result_src = rs;
      ex_pc_plus4   = a + 32'h4;
      #1;
   endtask

   // load acked in its first BUSY cycle; leaves a bubble in EX/MEM afterwards
   task automatic load_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
      issue(1, 1, 0, f3, a, 0, 5'd5, 1, RES_MEM);
      tick();
      be_seen        = dmem_be;
      we_seen        = dmem_we;
      addr_seen      = dmem_addr;
      dmem_rdata     = rdata;
      dmem_ack       = 1'b1;
      #1;
      stall_ack_seen = stall_o;
      tick();
      dmem_ack = 1'b0;
      issue(0, 0, 0, 0, 0, 0, 0, 0, RES_ALU);
   endtask

   task automatic store_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      issue(1, 0, 1, f3, a, d, 5'd0, 0, RES_ALU);
      tick();
      be_seen    = dmem_be;
      we_seen    = dmem_we;
      addr_seen  = dmem_addr;
      wdata_seen = dmem_wdata;
      dmem_ack   = 1'b1;
      #1;
      stall_ack_seen = stall_o;
      tick();
      dmem_ack = 1'b0;
      issue(0, 0, 0, 0, 0, 0, 0, 0, RES_ALU);
   endtask

   initial begin
      rst_n      = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      issue(0, 0, 0, 0, 0, 0, 0, 0, RES_ALU);
      #11;
      chk("rst_req", dmem_req, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_be", dmem_be, 0);
      chk("rst_misalign", misalign_o, 0);
      chk("rst_bus_err", bus_err_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // bubble
      chk("bubble_stall", stall_o, 0);
      tick();
      chk("bubble_wb_valid", wb_valid, 0);

      // SW 0x100, ack one cycle after req rises
      issue(1, 0, 1, F3_W, 32'h100, 32'hDEADBEEF, 5'd0, 0, RES_ALU);
      chk("sw_stall_idle", stall_o, 1);
      chk("sw_req_idle", dmem_req, 0);
      tick();
      chk("sw_req", dmem_req, 1);
      chk("sw_we", dmem_we, 1);
      chk("sw_be", dmem_be, 4'b1111);
      chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
      chk("sw_addr", dmem_addr, 32'h100);
      chk("sw_stall_busy1", stall_o, 1);
      tick();
      chk("sw_wb_valid_early", wb_valid, 0);
      dmem_ack = 1'b1;
      #1;
      chk("sw_stall_ack", stall_o, 0);
      tick();
      dmem_ack = 1'b0;
      issue(0, 0, 0, 0, 0, 0, 0, 0, RES_ALU);
      chk("sw_wb_valid", wb_valid, 1);
      chk("sw_wb_reg_write", wb_reg_write, 0);
      chk("sw_req_after", dmem_req, 0);

      // loads from word 0x80123456
      load_op(F3_B, 32'h103, 32'h80123456);
      chk("lb_be", be_seen, 4'b1000);
      chk("lb_we", we_seen, 0);
      chk("lb_addr", addr_seen, 32'h100);
      chk("lb_stall_ack", stall_ack_seen, 0);
      chk("lb_data", wb_mem_data, 32'hFFFFFF80);
      chk("lb_reg_write", wb_reg_write, 1);
      chk("lb_rd", wb_rd, 5);
      chk("lb_src", wb_result_src, RES_MEM);
      load_op(F3_BU, 32'h103, 32'h80123456);
      chk("lbu_data", wb_mem_data, 32'h00000080);
      load_op(F3_H, 32'h102, 32'h80123456);
      chk("lh_be", be_seen, 4'b1100);
      chk("lh_data", wb_mem_data, 32'hFFFF8012);
      load_op(F3_HU, 32'h100, 32'h80128456);
      chk("lhu_data", wb_mem_data, 32'h00008456);

      // sub-word stores
      store_op(F3_H, 32'h102, 32'h00001234);
      chk("sh_be", be_seen, 4'b1100);
      chk("sh_wdata", wdata_seen, 32'h12341234);
      chk("sh_addr", addr_seen, 32'h100);
      store_op(F3_B, 32'h101, 32'h000000AB);
      chk("sb_be", be_seen, 4'b0010);
      chk("sb_wdata", wdata_seen, 32'hABABABAB);
      chk("sb_reg_write", wb_reg_write, 0);

      // misaligned LW
      issue(1, 1, 0, F3_W, 32'h101, 0, 5'd9, 1, RES_MEM);
      chk("mis_stall", stall_o, 0);
      chk("mis_req", dmem_req, 0);
      tick();
      issue(0, 0, 0, 0, 0, 0, 0, 0, RES_ALU);
      chk("mis_pulse", misalign_o, 1);
      chk("mis_req2", dmem_req, 0);
      chk("mis_wb_valid", wb_valid, 1);
      chk("mis_reg_write", wb_reg_write, 0);
      tick();
      chk("mis_pulse_end", misalign_o, 0);

      // timeout: ack never arrives, four BUSY cycles then abort
      issue(1, 1, 0, F3_W, 32'h200, 0, 5'd6, 1, RES_MEM);
      chk("tmo_stall_idle", stall_o, 1);
      tick();
      chk("tmo_req1", dmem_req, 1);
      tick();
      chk("tmo_req2", dmem_req, 1);
      tick();
      chk("tmo_stall3", stall_o, 1);
      tick();
      chk("tmo_req4", dmem_req, 1);
      chk("tmo_stall4", stall_o, 0);
      chk("tmo_err_early", bus_err_o, 0);
      tick();
      chk("tmo_err", bus_err_o, 1);
      chk("tmo_req_drop", dmem_req, 0);
      chk("tmo_wb_valid", wb_valid, 1);
      chk("tmo_reg_write", wb_reg_write, 0);
      chk("tmo_mem_data", wb_mem_data, 0);
      issue(1, 0, 0, F3_B, 32'h55, 0, 5'd7, 1, RES_ALU);
      chk("tmo_next_stall", stall_o, 0);
      tick();
      issue(0, 0, 0, 0, 0, 0, 0, 0, RES_ALU);
      chk("tmo_err_end", bus_err_o, 0);
      chk("tmo_next_rd", wb_rd, 7);
      chk("tmo_next_alu", wb_alu_result, 32'h55);

      // ack coincides with the timeout cycle: normal completion
      issue(1, 1, 0, F3_W, 32'h204, 0, 5'd8, 1, RES_MEM);
      tick();
      tick();
      tick();
      tick();
      dmem_rdata = 32'h11223344;
      dmem_ack   = 1'b1;
      #1;
      tick();
      dmem_ack = 1'b0;
      issue(0, 0, 0, 0, 0, 0, 0, 0, RES_ALU);
      chk("tie_err", bus_err_o, 0);
      chk("tie_data", wb_mem_data, 32'h11223344);
      chk("tie_reg_write", wb_reg_write, 1);

      // async reset in the middle of an access
      issue(1, 1, 0, F3_W, 32'h300, 0, 5'd4, 1, RES_MEM);
      tick();
      chk("rstb_req", dmem_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstb_req_drop", dmem_req, 0);
      chk("rstb_stall", stall_o, 0);
      chk("rstb_be", dmem_be, 0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(1, 0, 0, 0, 32'h1234, 0, 5'd3, 1, RES_ALU);
      chk("add_stall", stall_o, 0);
      tick();
      issue(0, 0, 0, 0, 0, 0, 0, 0, RES_ALU);
      chk("add_wb_valid", wb_valid, 1);
      chk("add_rd", wb_rd, 3);
      chk("add_alu", wb_alu_result, 32'h1234);
      chk("add_pc4", wb_pc_plus4, 32'h1238);
      chk("add_src", wb_result_src, RES_ALU);
      chk("add_no_reissue", dmem_req, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
